// File: rtl/centroid_sched_pkg.sv
// Shared types and constants for the centroid FIFO write scheduler.
// Holds delay width, default/min delay, FSM states and the delay clamp.
package centroid_sched_pkg;

    localparam int DELAY_W = 8;
    localparam logic [DELAY_W-1:0] DEFAULT_DELAY = DELAY_W'(40);
    localparam logic [DELAY_W-1:0] MIN_DELAY = DELAY_W'(2);

    typedef enum logic {
        ST_RUN,
        ST_DRAIN
    } sched_state_t;

    function automatic logic [DELAY_W-1:0] clamp_delay(
        input logic [DELAY_W-1:0] d
    );
        return (d < MIN_DELAY) ? MIN_DELAY : d;
    endfunction

endpackage

// File: rtl/sched_pending_queue.sv
// Circular FIFO of due timestamps for the write scheduler.
// Head is read combinationally; push while full is accepted only with a pop.
module sched_pending_queue #(
    parameter int W = 8,
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk_200MHz_i,
    input  logic          rst_n_i,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk_200MHz_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk_200MHz_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/centroid_fifo_write_sched.sv
// Programmable-delay write scheduler in front of the centroid FIFO.
// Timestamps each flag and issues one write strobe when its delay expires.
module centroid_fifo_write_sched
    import centroid_sched_pkg::*;
#(
    parameter int MAX_PENDING = 64,
    parameter int CNT_W = 16,
    localparam int PW = $clog2(MAX_PENDING) + 1
) (
    input  logic               clk_200MHz_i,
    input  logic               rst_n_i,
    input  logic               centroid_flag_i,
    input  logic               fifo_full_i,
    input  logic [DELAY_W-1:0] delay_cfg_i,
    input  logic               cfg_load_i,
    output logic               fifo_wr_en_o,
    output logic               busy_o,
    output logic [PW-1:0]      pending_cnt_o,
    output logic [CNT_W-1:0]   drop_cnt_o,
    output logic               overflow_o,
    output logic [DELAY_W-1:0] delay_act_o
);

    sched_state_t       state_q;
    logic [DELAY_W-1:0] ts_q;
    logic [DELAY_W-1:0] delay_act_q;
    logic [DELAY_W-1:0] delay_pend_q;
    logic [DELAY_W-1:0] cfg_clamped;
    logic               wr_en_q;
    logic               overflow_q;
    logic [CNT_W-1:0]   drop_cnt_q;

    logic [DELAY_W-1:0] head;
    logic [PW-1:0]      count;
    logic               full;
    logic               empty;

    logic               pop;
    logic               last_pop;
    logic               push_ok;
    logic               push_drop;
    logic               pop_drop;
    logic [1:0]         drop_inc;
    logic [CNT_W:0]     drop_sum;

    // Pop one cycle early: the registered strobe supplies the final stage.
    assign pop       = !empty && (head == ts_q + DELAY_W'(1));
    assign last_pop  = pop && (count == PW'(1));
    assign push_ok   = centroid_flag_i && (state_q == ST_RUN) && (!full || pop);
    assign push_drop = centroid_flag_i && !push_ok;
    assign pop_drop  = pop && fifo_full_i;
    assign drop_inc  = {1'b0, push_drop} + {1'b0, pop_drop};
    assign drop_sum  = {1'b0, drop_cnt_q} + (CNT_W + 1)'(drop_inc);
    assign cfg_clamped = clamp_delay(delay_cfg_i);

    sched_pending_queue #(
        .W     (DELAY_W),
        .DEPTH (MAX_PENDING)
    ) u_queue (
        .clk_200MHz_i (clk_200MHz_i),
        .rst_n_i      (rst_n_i),
        .push         (push_ok),
        .pop          (pop),
        .din          (ts_q + delay_act_q),
        .head         (head),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    always_ff @(posedge clk_200MHz_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_RUN;
            ts_q         <= '0;
            delay_act_q  <= DEFAULT_DELAY;
            delay_pend_q <= DEFAULT_DELAY;
            wr_en_q      <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            ts_q    <= ts_q + DELAY_W'(1);
            wr_en_q <= pop && !fifo_full_i;
            if (drop_inc != 2'd0) begin
                overflow_q <= 1'b1;
                drop_cnt_q <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            end
            unique case (state_q)
                ST_RUN: begin
                    if (cfg_load_i) begin
                        if (empty || last_pop) begin
                            delay_act_q <= cfg_clamped;
                        end else begin
                            delay_pend_q <= cfg_clamped;
                            state_q      <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cfg_load_i) begin
                        delay_pend_q <= cfg_clamped;
                    end
                    if (empty) begin
                        delay_act_q <= cfg_load_i ? cfg_clamped : delay_pend_q;
                        state_q     <= ST_RUN;
                    end
                end
            endcase
        end
    end

    assign fifo_wr_en_o  = wr_en_q;
    assign busy_o        = !empty || (state_q == ST_DRAIN);
    assign pending_cnt_o = count;
    assign drop_cnt_o    = drop_cnt_q;
    assign overflow_o    = overflow_q;
    assign delay_act_o   = delay_act_q;

endmodule

// File: tb/tb_centroid_fifo_write_sched.sv
// Scoreboard bench for centroid_fifo_write_sched.
// Expected strobe cycles are queued at flag time and popped on each strobe.
module tb_centroid_fifo_write_sched;

    logic       clk_200MHz_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       centroid_flag_i = 1'b0;
    logic       fifo_full_i = 1'b0;
    logic [7:0] delay_cfg_i = '0;
    logic       cfg_load_i = 1'b0;
    logic       fifo_wr_en_o;
    logic       busy_o;
    logic [6:0] pending_cnt_o;
    logic [15:0] drop_cnt_o;
    logic       overflow_o;
    logic [7:0] delay_act_o;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int d_m = 40;
    int ts_m = 0;
    int exp_q[$];

    centroid_fifo_write_sched #(
        .MAX_PENDING (64),
        .CNT_W       (16)
    ) dut (
        .clk_200MHz_i    (clk_200MHz_i),
        .rst_n_i         (rst_n_i),
        .centroid_flag_i (centroid_flag_i),
        .fifo_full_i     (fifo_full_i),
        .delay_cfg_i     (delay_cfg_i),
        .cfg_load_i      (cfg_load_i),
        .fifo_wr_en_o    (fifo_wr_en_o),
        .busy_o          (busy_o),
        .pending_cnt_o   (pending_cnt_o),
        .drop_cnt_o      (drop_cnt_o),
        .overflow_o      (overflow_o),
        .delay_act_o     (delay_act_o)
    );

    always #5 clk_200MHz_i = ~clk_200MHz_i;

    always @(posedge clk_200MHz_i) cyc <= cyc + 1;

    always @(posedge clk_200MHz_i or negedge rst_n_i) begin
        if (!rst_n_i) ts_m <= 0;
        else ts_m <= (ts_m + 1) % 256;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk_200MHz_i) begin
        if (rst_n_i && fifo_wr_en_o) begin
            if (exp_q.size() == 0)
                chk("strobe_unexpected", int'(fifo_wr_en_o), 0);
            else
                chk("strobe_cycle", cyc, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk_200MHz_i);
        #1;
    endtask

    task automatic load_cfg(input int v);
        delay_cfg_i = 8'(v);
        cfg_load_i = 1'b1;
        tick();
        cfg_load_i = 1'b0;
        d_m = (v < 2) ? 2 : v;
    endtask

    task automatic flag(input int n);
        for (int i = 0; i < n; i++) begin
            centroid_flag_i = 1'b1;
            exp_q.push_back(cyc + d_m);
            tick();
        end
        centroid_flag_i = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && (exp_q.size() != 0 || busy_o); i++)
            tick();
        chk("drain_left", exp_q.size(), 0);
        chk("drain_busy", int'(busy_o), 0);
    endtask

    initial begin
        int n0;
        repeat (3) tick();
        chk("rst_wr_en", int'(fifo_wr_en_o), 0);
        chk("rst_delay", int'(delay_act_o), 40);
        rst_n_i = 1'b1;
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_pending", int'(pending_cnt_o), 0);
        chk("rst_drop", int'(drop_cnt_o), 0);
        chk("rst_ovf", int'(overflow_o), 0);

        // default delay, single flag
        repeat (8) tick();
        flag(1);
        chk("def_busy", int'(busy_o), 1);
        chk("def_pending", int'(pending_cnt_o), 1);
        wait_drain(100);
        chk("def_drop", int'(drop_cnt_o), 0);

        // delay 3, five back-to-back flags
        load_cfg(3);
        chk("cfg3_delay", int'(delay_act_o), 3);
        flag(5);
        wait_drain(50);

        // delay 0 clamps to 2
        load_cfg(0);
        chk("cfg0_delay", int'(delay_act_o), 2);
        flag(1);
        wait_drain(50);

        // timestamp wrap
        load_cfg(200);
        chk("cfg200_delay", int'(delay_act_o), 200);
        for (int i = 0; i < 300 && ts_m != 250; i++) tick();
        flag(1);
        wait_drain(300);
        chk("wrap_drop", int'(drop_cnt_o), 0);

        // FIFO full at the first due cycle
        load_cfg(5);
        n0 = cyc;
        centroid_flag_i = 1'b1;
        tick();
        flag(1);
        for (int i = 0; i < 20 && cyc < n0 + 4; i++) tick();
        fifo_full_i = 1'b1;
        tick();
        fifo_full_i = 1'b0;
        wait_drain(50);
        chk("full_drop", int'(drop_cnt_o), 1);
        chk("full_ovf", int'(overflow_o), 1);

        // queue overflow then config drain
        load_cfg(255);
        for (int i = 0; i < 70; i++) begin
            centroid_flag_i = 1'b1;
            if (i < 64) exp_q.push_back(cyc + d_m);
            tick();
        end
        centroid_flag_i = 1'b0;
        chk("ovf_pending", int'(pending_cnt_o), 64);
        chk("ovf_drop", int'(drop_cnt_o), 7);
        delay_cfg_i = 8'd10;
        cfg_load_i = 1'b1;
        tick();
        cfg_load_i = 1'b0;
        chk("drain_busy_hi", int'(busy_o), 1);
        chk("drain_old_delay", int'(delay_act_o), 255);
        centroid_flag_i = 1'b1;
        tick();
        centroid_flag_i = 1'b0;
        chk("drain_flag_drop", int'(drop_cnt_o), 8);
        chk("drain_pending", int'(pending_cnt_o), 64);
        wait_drain(400);
        d_m = 10;
        chk("drain_new_delay", int'(delay_act_o), 10);
        flag(1);
        wait_drain(50);
        chk("final_drop", int'(drop_cnt_o), 8);

        // reset with an event in flight
        flag(1);
        repeat (3) tick();
        rst_n_i = 1'b0;
        exp_q.delete();
        d_m = 40;
        tick();
        chk("rst2_pending", int'(pending_cnt_o), 0);
        chk("rst2_drop", int'(drop_cnt_o), 0);
        chk("rst2_ovf", int'(overflow_o), 0);
        chk("rst2_delay", int'(delay_act_o), 40);
        rst_n_i = 1'b1;
        repeat (30) tick();
        chk("rst2_busy", int'(busy_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
